pit_multi_channel: RTL

- Multi-channel programmable interval timer; parametrised successor of the single-channel mini PIT.
- CHANNELS independent down-counters, each with its own reload value, prescaler, one-shot/periodic mode and pulse/sticky interrupt.
- Programmed over a byte-wide write port driven from the tile's dedicated input pins.
- Interrupts and per-channel status go to the tile's output pins.

---
 rtl/pit_multi_channel.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pit_multi_channel.sv
// Multi-channel programmable interval timer: CHANNELS independent prescaled
// down-counters programmed through a byte-wide register write port.
module pit_multi_channel #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_W    = 16,
    parameter int PRESCALE_W = 8,
    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SEL_W+1:0]    wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] irq_ack,
    input  logic [SEL_W-1:0]    mon_sel,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any,
    output logic [CHANNELS-1:0] active,
    output logic [COUNT_W-1:0]  mon_count
);
    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_RELOAD_LO = 2'd1;
    localparam logic [1:0] REG_RELOAD_HI = 2'd2;

    logic [COUNT_W-1:0] w_count [CHANNELS];
    logic [SEL_W-1:0]   w_wr_ch;
    logic [1:0]         w_wr_reg;

    assign w_wr_ch  = wr_addr[SEL_W+1:2];
    assign w_wr_reg = wr_addr[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // r_ctrl holds {sticky, prescale_en, periodic, enable}; restart is never stored
        logic [3:0]            r_ctrl;
        logic [COUNT_W-1:0]    r_reload;
        logic [COUNT_W-1:0]    r_count;
        logic [PRESCALE_W-1:0] r_prescale;
        logic [PRESCALE_W-1:0] r_presc_cnt;
        logic                  r_irq;

        logic [3:0]            w_ctrl_nx;
        logic [COUNT_W-1:0]    w_reload_nx;
        logic [COUNT_W-1:0]    w_count_nx;
        logic [PRESCALE_W-1:0] w_prescale_nx;
        logic [PRESCALE_W-1:0] w_presc_nx;
        logic                  w_irq_nx;
        logic                  w_sel;
        logic                  w_tick;
        logic                  w_expire;
        logic [15:0]           w_reload_wide;

        assign w_sel = wr_en && (w_wr_ch == SEL_W'(g));

        // Next state: tick and expiry first, then a register write overrides them.
        always_comb begin
            w_ctrl_nx     = r_ctrl;
            w_reload_nx   = r_reload;
            w_count_nx    = r_count;
            w_prescale_nx = r_prescale;
            w_presc_nx    = r_presc_cnt;
            w_irq_nx      = 1'b0;
            w_tick        = 1'b0;
            w_expire      = 1'b0;
            w_reload_wide = 16'(r_reload);

            if (r_ctrl[0]) begin
                w_tick = !r_ctrl[2] || (r_presc_cnt == r_prescale);
                if (r_ctrl[2]) begin
                    w_presc_nx = w_tick ? {PRESCALE_W{1'b0}} : r_presc_cnt + PRESCALE_W'(1);
                end else begin
                    w_presc_nx = r_presc_cnt;
                end
                if (w_tick) begin
                    if (r_count != {COUNT_W{1'b0}}) begin
                        w_count_nx = r_count - COUNT_W'(1);
                    end else begin
                        // zero is only ever left through expiry, so no underflow
                        w_expire = 1'b1;
                        if (r_ctrl[1]) begin
                            w_count_nx = r_reload;
                        end else begin
                            w_ctrl_nx[0] = 1'b0;
                            w_count_nx   = r_count;
                        end
                    end
                end else begin
                    w_count_nx = r_count;
                end
            end else begin
                w_tick = 1'b0;
            end

            if (w_sel) begin
                case (w_wr_reg)
                    REG_CTRL: begin
                        w_ctrl_nx = wr_data[3:0];
                        w_expire  = 1'b0;
                        if (wr_data[0] || wr_data[4]) begin
                            w_count_nx = r_reload;
                            w_presc_nx = {PRESCALE_W{1'b0}};
                        end else begin
                            w_count_nx = r_count;
                            w_presc_nx = r_presc_cnt;
                        end
                    end
                    REG_RELOAD_LO: begin
                        w_reload_wide[7:0] = wr_data;
                        w_reload_nx        = w_reload_wide[COUNT_W-1:0];
                    end
                    REG_RELOAD_HI: begin
                        w_reload_wide[15:8] = wr_data;
                        w_reload_nx         = w_reload_wide[COUNT_W-1:0];
                    end
                    default: begin
                        w_prescale_nx = wr_data[PRESCALE_W-1:0];
                    end
                endcase
            end else begin
                w_reload_nx = r_reload;
            end

            // a new expiry beats a simultaneous ack
            if (w_expire) begin
                w_irq_nx = 1'b1;
            end else if (r_ctrl[3]) begin
                w_irq_nx = r_irq && !irq_ack[g];
            end else begin
                w_irq_nx = 1'b0;
            end
        end

        // Channel state registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ctrl      <= 4'd0;
                r_reload    <= {COUNT_W{1'b0}};
                r_count     <= {COUNT_W{1'b0}};
                r_prescale  <= {PRESCALE_W{1'b0}};
                r_presc_cnt <= {PRESCALE_W{1'b0}};
                r_irq       <= 1'b0;
            end else begin
                r_ctrl      <= w_ctrl_nx;
                r_reload    <= w_reload_nx;
                r_count     <= w_count_nx;
                r_prescale  <= w_prescale_nx;
                r_presc_cnt <= w_presc_nx;
                r_irq       <= w_irq_nx;
            end
        end

        assign w_count[g] = r_count;
        assign irq[g]     = r_irq;
        assign active[g]  = r_ctrl[0];
    end

    assign irq_any = |irq;

    // Count monitor; a selection beyond the last channel reads as zero.
    always_comb begin
        mon_count = {COUNT_W{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            mon_count = mon_count | ((mon_sel == SEL_W'(i)) ? w_count[i] : {COUNT_W{1'b0}});
        end
    end
endmodule
